// File: rtl/dmem_responder.sv
// Data-memory responder for the darksocv core data bus: stalls the core for a
// fixed number of wait states, then completes one load or store against a word window.
module dmem_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int BASE_WORD   = 512,
    parameter int DEPTH_WORDS = 512
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    input  logic [3:0]  BE,
    input  logic        RD,
    input  logic        WR,
    output logic [31:0] DATAI,
    output logic        HLT,
    output logic        ERR,
    output logic [15:0] ERR_CNT
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LO_WORD  = 32'(BASE_WORD);
    localparam logic [31:0] HI_WORD  = 32'(BASE_WORD + DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_nxt_s;
    logic [29:0]   addr_r;
    logic [31:0]   data_r;
    logic [3:0]    be_r;
    logic          rd_r;
    logic          wr_r;
    logic [31:0]   datai_r;
    logic          err_r;
    logic [15:0]   err_cnt_r;
    logic [31:0]   mem_r [DEPTH_WORDS];

    logic          req_s;
    logic          enter_resp_s;
    logic          leave_resp_s;
    logic          store_ok_s;
    logic [29:0]   cur_word_s;
    logic          cur_rd_s;
    logic          cur_wr_s;
    logic          in_range_s;
    logic          cur_err_s;
    logic [AW-1:0] offset_s;
    logic          unused_addr_s;

    assign req_s         = RD | WR;
    assign unused_addr_s = ^DADDR[1:0];

    // Request under evaluation: live bus inputs while idle, the latched copy afterwards.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_word_s = DADDR[31:2];
            cur_rd_s   = RD;
            cur_wr_s   = WR;
        end else begin
            cur_word_s = addr_r;
            cur_rd_s   = rd_r;
            cur_wr_s   = wr_r;
        end
        in_range_s = ({2'b00, cur_word_s} >= LO_WORD) && ({2'b00, cur_word_s} < HI_WORD);
        offset_s   = AW'({2'b00, cur_word_s} - LO_WORD);
        cur_err_s  = (cur_rd_s && cur_wr_s) || ((cur_rd_s || cur_wr_s) && !in_range_s);
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    cnt_nxt_s   = CNT_INIT;
                    state_nxt_s = (CNT_INIT != 4'd0) ? ST_WAIT : ST_RESP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_nxt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    assign enter_resp_s = (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
    assign leave_resp_s = (state_r == ST_RESP);
    assign store_ok_s   = leave_resp_s && wr_r && !rd_r && in_range_s;

    // HLT is gated by reset so that it drops the moment reset asserts.
    assign HLT     = RES && (((state_r == ST_IDLE) && req_s) || (state_r == ST_WAIT));
    assign DATAI   = datai_r;
    assign ERR     = err_r;
    assign ERR_CNT = err_cnt_r;

    // State and wait-counter registers.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Request latch, captured on acceptance in IDLE.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            addr_r <= 30'd0;
            data_r <= 32'd0;
            be_r   <= 4'd0;
            rd_r   <= 1'b0;
            wr_r   <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_s) begin
            addr_r <= DADDR[31:2];
            data_r <= DATAO;
            be_r   <= BE;
            rd_r   <= RD;
            wr_r   <= WR;
        end
    end

    // Load data and error flag, updated on the edge entering RESP.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            datai_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            err_r <= enter_resp_s && cur_err_s;
            if (enter_resp_s && cur_rd_s) begin
                datai_r <= cur_err_s ? 32'd0 : mem_r[offset_s];
            end
        end
    end

    // Saturating error counter, stepped on the edge leaving RESP.
    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            err_cnt_r <= 16'd0;
        end else if (leave_resp_s && err_r && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end
    end

    // Byte-merged store commit; the array itself is never reset.
    always_ff @(posedge CLK) begin
        if (store_ok_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_r[i]) begin
                    mem_r[offset_s][8*i +: 8] <= data_r[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (1 and 3 wait states) driven by
// directed and random accesses, checked against a word-array reference model.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        res     [2];
    logic [31:0] daddr   [2];
    logic [31:0] datao   [2];
    logic [3:0]  be      [2];
    logic        rd      [2];
    logic        wr      [2];
    logic [31:0] datai   [2];
    logic        hlt     [2];
    logic        err     [2];
    logic [15:0] err_cnt [2];

    dmem_responder #(.WAIT_CYCLES(1)) dut0 (
        .CLK(clk), .RES(res[0]), .DADDR(daddr[0]), .DATAO(datao[0]), .BE(be[0]),
        .RD(rd[0]), .WR(wr[0]), .DATAI(datai[0]), .HLT(hlt[0]), .ERR(err[0]),
        .ERR_CNT(err_cnt[0])
    );

    dmem_responder #(.WAIT_CYCLES(3)) dut1 (
        .CLK(clk), .RES(res[1]), .DADDR(daddr[1]), .DATAO(datao[1]), .BE(be[1]),
        .RD(rd[1]), .WR(wr[1]), .DATAI(datai[1]), .HLT(hlt[1]), .ERR(err[1]),
        .ERR_CNT(err_cnt[1])
    );

    int total = 0;
    int bad   = 0;

    // reference model: window contents, last load result, error count
    logic [31:0] m_mem   [2][512];
    logic [31:0] m_datai [2];
    logic [15:0] m_cnt   [2];
    logic        exp_err;

    // observations captured by run_access
    int          obs_hcnt;
    logic        obs_err;
    logic [31:0] obs_datai;
    logic        obs_err_after;
    logic [15:0] obs_cnt;
    int          acc_cyc;

    function automatic int wc(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    function automatic void mdl_step(input int s, input logic [31:0] a, input logic [31:0] d,
                                     input logic [3:0] b, input logic r, input logic w);
        int word;
        bit inr;
        word    = int'(a[31:2]);
        inr     = (word >= 512) && (word < 1024);
        exp_err = (r && w) || !inr;
        if (r) m_datai[s] = exp_err ? 32'h0 : m_mem[s][word-512];
        if (w && !r && inr) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) m_mem[s][word-512][8*i +: 8] = d[8*i +: 8];
        end
        if (exp_err && m_cnt[s] != 16'hFFFF) m_cnt[s] = m_cnt[s] + 16'd1;
    endfunction

    // Issue one access; the bus is scrambled while stalled to show it is ignored.
    task automatic run_access(input int s, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b, input logic r, input logic w);
        @(negedge clk);
        daddr[s] = a; datao[s] = d; be[s] = b; rd[s] = r; wr[s] = w;
        acc_cyc  = cyc;
        #1;
        obs_hcnt = 0;
        while (hlt[s] === 1'b1 && obs_hcnt < 20) begin
            obs_hcnt++;
            @(posedge clk); #1;
            rd[s] = 1'b0; wr[s] = 1'b0;
            daddr[s] = $urandom; datao[s] = $urandom; be[s] = 4'($urandom);
            #1;
        end
        obs_err   = err[s];
        obs_datai = datai[s];
        @(posedge clk); #1;
        obs_err_after = err[s];
        obs_cnt       = err_cnt[s];
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            res[s] = 1'b0; rd[s] = 1'b0; wr[s] = 1'b0;
            daddr[s] = 32'h0; datao[s] = 32'h0; be[s] = 4'h0;
            m_datai[s] = 32'h0; m_cnt[s] = 16'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            total++; if (hlt[s] !== 1'b0) begin bad++; $display("FAIL reset_hlt s=%0d got=%b exp=0", s, hlt[s]); end
            total++; if (err[s] !== 1'b0) begin bad++; $display("FAIL reset_err s=%0d got=%b exp=0", s, err[s]); end
            total++; if (err_cnt[s] !== 16'h0) begin bad++; $display("FAIL reset_cnt s=%0d got=%h exp=0", s, err_cnt[s]); end
            total++; if (datai[s] !== 32'h0) begin bad++; $display("FAIL reset_datai s=%0d got=%h exp=0", s, datai[s]); end
            res[s] = 1'b1;
        end
    endtask

    task automatic test_fill(input int s);
        logic [31:0] a, d;
        for (int w = 0; w < 512; w++) begin
            a = 32'h800 + 32'(w * 4);
            d = $urandom;
            run_access(s, a, d, 4'hF, 1'b0, 1'b1);
            mdl_step(s, a, d, 4'hF, 1'b0, 1'b1);
            total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL fill_err s=%0d w=%0d got=%b exp=0", s, w, obs_err); end
        end
    endtask

    task automatic test_store_load();
        run_access(0, 32'h800, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
        mdl_step(0, 32'h800, 32'hDEADBEEF, 4'hF, 1'b0, 1'b1);
        total++; if (obs_hcnt !== 1) begin bad++; $display("FAIL sl_st_hlt got=%0d exp=1", obs_hcnt); end
        total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL sl_st_err got=%b exp=0", obs_err); end
        run_access(0, 32'h800, 32'h0, 4'h0, 1'b1, 1'b0);
        mdl_step(0, 32'h800, 32'h0, 4'h0, 1'b1, 1'b0);
        total++; if (obs_hcnt !== 1) begin bad++; $display("FAIL sl_ld_hlt got=%0d exp=1", obs_hcnt); end
        total++; if (obs_datai !== 32'hDEADBEEF) begin bad++; $display("FAIL sl_ld_data got=%h exp=deadbeef", obs_datai); end
        total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL sl_ld_err got=%b exp=0", obs_err); end
    endtask

    task automatic test_byte_merge();
        run_access(0, 32'h800, 32'h000000AA, 4'b0001, 1'b0, 1'b1);
        mdl_step(0, 32'h800, 32'h000000AA, 4'b0001, 1'b0, 1'b1);
        run_access(0, 32'h800, 32'h0, 4'h0, 1'b1, 1'b0);
        mdl_step(0, 32'h800, 32'h0, 4'h0, 1'b1, 1'b0);
        total++; if (obs_datai !== 32'hDEADBEAA) begin bad++; $display("FAIL merge_be1 got=%h exp=deadbeaa", obs_datai); end
        run_access(0, 32'h800, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b1);
        mdl_step(0, 32'h800, 32'hFFFFFFFF, 4'b0000, 1'b0, 1'b1);
        total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL merge_be0_err got=%b exp=0", obs_err); end
        run_access(0, 32'h800, 32'h0, 4'h0, 1'b1, 1'b0);
        mdl_step(0, 32'h800, 32'h0, 4'h0, 1'b1, 1'b0);
        total++; if (obs_datai !== 32'hDEADBEAA) begin bad++; $display("FAIL merge_be0 got=%h exp=deadbeaa", obs_datai); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs [2];
        addrs[0] = 32'h1000;
        addrs[1] = 32'h7FC;
        for (int k = 0; k < 2; k++) begin
            run_access(0, addrs[k], 32'h0, 4'h0, 1'b1, 1'b0);
            mdl_step(0, addrs[k], 32'h0, 4'h0, 1'b1, 1'b0);
            total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL oor_err a=%h got=%b exp=1", addrs[k], obs_err); end
            total++; if (obs_err_after !== 1'b0) begin bad++; $display("FAIL oor_pulse a=%h got=%b exp=0", addrs[k], obs_err_after); end
            total++; if (obs_datai !== 32'h0) begin bad++; $display("FAIL oor_data a=%h got=%h exp=0", addrs[k], obs_datai); end
        end
        total++; if (obs_cnt !== 16'd2) begin bad++; $display("FAIL oor_cnt got=%0d exp=2", obs_cnt); end
        run_access(0, 32'h1000, 32'h55555555, 4'hF, 1'b0, 1'b1);
        mdl_step(0, 32'h1000, 32'h55555555, 4'hF, 1'b0, 1'b1);
        run_access(0, 32'h800, 32'h0, 4'h0, 1'b1, 1'b0);
        mdl_step(0, 32'h800, 32'h0, 4'h0, 1'b1, 1'b0);
        total++; if (obs_datai !== m_datai[0]) begin bad++; $display("FAIL oor_store_drop got=%h exp=%h", obs_datai, m_datai[0]); end
        total++; if (obs_cnt !== m_cnt[0]) begin bad++; $display("FAIL oor_cnt3 got=%0d exp=%0d", obs_cnt, m_cnt[0]); end
    endtask

    task automatic test_wait3();
        run_access(1, 32'hFFC, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1);
        mdl_step(1, 32'hFFC, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1);
        total++; if (obs_hcnt !== 3) begin bad++; $display("FAIL w3_st_hlt got=%0d exp=3", obs_hcnt); end
        run_access(1, 32'hFFC, 32'h0, 4'h0, 1'b1, 1'b0);
        mdl_step(1, 32'hFFC, 32'h0, 4'h0, 1'b1, 1'b0);
        total++; if (obs_hcnt !== 3) begin bad++; $display("FAIL w3_ld_hlt got=%0d exp=3", obs_hcnt); end
        total++; if (obs_datai !== 32'hCAFEF00D) begin bad++; $display("FAIL w3_ld_data got=%h exp=cafef00d", obs_datai); end
    endtask

    task automatic test_back_to_back();
        int c0;
        run_access(1, 32'h804, 32'h0, 4'h0, 1'b1, 1'b0);
        mdl_step(1, 32'h804, 32'h0, 4'h0, 1'b1, 1'b0);
        c0 = acc_cyc;
        run_access(1, 32'hFFC, 32'h0, 4'h0, 1'b1, 1'b0);
        mdl_step(1, 32'hFFC, 32'h0, 4'h0, 1'b1, 1'b0);
        total++; if (acc_cyc - c0 !== 4) begin bad++; $display("FAIL b2b_gap got=%0d exp=4", acc_cyc - c0); end
        total++; if (obs_hcnt !== 3) begin bad++; $display("FAIL b2b_hlt got=%0d exp=3", obs_hcnt); end
        total++; if (obs_datai !== m_datai[1]) begin bad++; $display("FAIL b2b_data got=%h exp=%h", obs_datai, m_datai[1]); end
    endtask

    task automatic test_random(input int s);
        logic [29:0] word;
        logic [31:0] a, d;
        logic [3:0]  b;
        logic        r, w;
        int          sel, op;
        for (int k = 0; k < 120; k++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       word = 30'd511;
                1:       word = 30'd1024;
                2:       word = 30'd512;
                3:       word = 30'd1023;
                4:       word = 30'($urandom);
                default: word = 30'($urandom_range(512, 1023));
            endcase
            a  = {word, 2'($urandom)};
            op = $urandom_range(0, 9);
            r  = (op < 5) || (op == 9);
            w  = (op >= 5);
            b  = 4'($urandom);
            d  = $urandom;
            run_access(s, a, d, b, r, w);
            mdl_step(s, a, d, b, r, w);
            total++; if (obs_hcnt !== wc(s)) begin bad++; $display("FAIL rnd_hlt s=%0d k=%0d got=%0d exp=%0d", s, k, obs_hcnt, wc(s)); end
            total++; if (obs_err !== exp_err) begin bad++; $display("FAIL rnd_err s=%0d k=%0d a=%h got=%b exp=%b", s, k, a, obs_err, exp_err); end
            total++; if (obs_datai !== m_datai[s]) begin bad++; $display("FAIL rnd_data s=%0d k=%0d a=%h got=%h exp=%h", s, k, a, obs_datai, m_datai[s]); end
            total++; if (obs_err_after !== 1'b0) begin bad++; $display("FAIL rnd_pulse s=%0d k=%0d got=%b exp=0", s, k, obs_err_after); end
            total++; if (obs_cnt !== m_cnt[s]) begin bad++; $display("FAIL rnd_cnt s=%0d k=%0d got=%0d exp=%0d", s, k, obs_cnt, m_cnt[s]); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] prior;
        prior = m_mem[1][(32'h900 >> 2) - 512];
        run_access(1, 32'h900, 32'h0, 4'h0, 1'b1, 1'b0);
        mdl_step(1, 32'h900, 32'h0, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        daddr[1] = 32'h900; datao[1] = 32'h12345678; be[1] = 4'hF; rd[1] = 1'b0; wr[1] = 1'b1;
        @(posedge clk); #1;
        wr[1] = 1'b0;
        @(posedge clk); #1;
        total++; if (hlt[1] !== 1'b1) begin bad++; $display("FAIL abort_pre_hlt got=%b exp=1", hlt[1]); end
        #1;
        res[1] = 1'b0;
        #1;
        total++; if (hlt[1] !== 1'b0) begin bad++; $display("FAIL abort_hlt got=%b exp=0", hlt[1]); end
        total++; if (err[1] !== 1'b0) begin bad++; $display("FAIL abort_err got=%b exp=0", err[1]); end
        total++; if (err_cnt[1] !== 16'h0) begin bad++; $display("FAIL abort_cnt got=%h exp=0", err_cnt[1]); end
        total++; if (datai[1] !== 32'h0) begin bad++; $display("FAIL abort_datai got=%h exp=0", datai[1]); end
        @(posedge clk); #1;
        res[1] = 1'b1;
        m_cnt[1] = 16'h0;
        m_datai[1] = 32'h0;
        run_access(1, 32'h900, 32'h0, 4'h0, 1'b1, 1'b0);
        mdl_step(1, 32'h900, 32'h0, 4'h0, 1'b1, 1'b0);
        total++; if (obs_datai !== prior) begin bad++; $display("FAIL abort_nocommit got=%h exp=%h", obs_datai, prior); end
    endtask

    task automatic test_rdwr();
        run_access(0, 32'h800, 32'h0BADF00D, 4'hF, 1'b1, 1'b1);
        mdl_step(0, 32'h800, 32'h0BADF00D, 4'hF, 1'b1, 1'b1);
        total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL rdwr_err got=%b exp=1", obs_err); end
        total++; if (obs_datai !== 32'h0) begin bad++; $display("FAIL rdwr_data got=%h exp=0", obs_datai); end
        total++; if (obs_cnt !== m_cnt[0]) begin bad++; $display("FAIL rdwr_cnt got=%0d exp=%0d", obs_cnt, m_cnt[0]); end
        run_access(0, 32'h800, 32'h0, 4'h0, 1'b1, 1'b0);
        mdl_step(0, 32'h800, 32'h0, 4'h0, 1'b1, 1'b0);
        total++; if (obs_datai !== m_datai[0]) begin bad++; $display("FAIL rdwr_mem got=%h exp=%h", obs_datai, m_datai[0]); end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut0.err_cnt_r = 16'hFFFC;
        @(posedge clk); #1;
        release dut0.err_cnt_r;
        m_cnt[0] = 16'hFFFC;
        for (int k = 0; k < 6; k++) begin
            run_access(0, 32'h2000, 32'h0, 4'h0, 1'b1, 1'b0);
            mdl_step(0, 32'h2000, 32'h0, 4'h0, 1'b1, 1'b0);
            total++; if (obs_cnt !== m_cnt[0]) begin bad++; $display("FAIL sat_cnt k=%0d got=%h exp=%h", k, obs_cnt, m_cnt[0]); end
        end
        total++; if (obs_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", obs_cnt); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill(0);
        test_fill(1);
        test_store_load();
        test_byte_merge();
        test_out_of_range();
        test_wait3();
        test_back_to_back();
        test_random(0);
        test_random(1);
        test_abort();
        test_rdwr();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
